// File: rtl/ysyx_24100006_scoreboard.sv
// Per-GPR pending-write scoreboard beside ID: marks rd on issue, clears it on WB retire.
// Optional macro SB_WB_BYPASS_EN lets a same-cycle retire release its waiting reader.
module ysyx_24100006_scoreboard #(
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned NR_REG = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_out_valid,
    input  logic       id_out_ready,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_rs1_ren,
    input  logic       id_rs2_ren,
    input  logic [3:0] id_rd,
    input  logic       id_wen,
    input  logic       wb_commit,
    input  logic [3:0] wb_rd,
    input  logic       wb_wen,
    output logic       stall_id,
    output logic       sb_empty,
    output logic       sb_err
);

    localparam int unsigned IDX_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt_q [1:NR_REG-1];
    logic [CNT_W-1:0]  cnt_d [1:NR_REG-1];
    logic              err_q;
    logic              err_d;
    logic [NR_REG-1:0] nz_v;
    logic [NR_REG-1:0] pend_v;
    logic [NR_REG-1:0] sat_v;
    logic [NR_REG-1:0] inc_v;
    logic [NR_REG-1:0] dec_v;
    logic              raw;
    logic              waw_sat;
    logic              iss;
    logic              ret;

    assign ret = wb_commit & wb_wen & (wb_rd != '0);

    // Per-register pending / saturated views; x0 is never pending.
    always_comb begin
        nz_v   = '0;
        pend_v = '0;
        sat_v  = '0;
        for (int unsigned r = 1; r < NR_REG; r++) begin
            nz_v[r]   = (cnt_q[r] != '0);
            pend_v[r] = (cnt_q[r] != '0);
            sat_v[r]  = (cnt_q[r] == CNT_MAX);
`ifdef SB_WB_BYPASS_EN
            // Write-first regfile: the last outstanding write retiring now is already visible.
            if (ret && (wb_rd == IDX_W'(r))) begin
                sat_v[r] = 1'b0;
                if (cnt_q[r] == CNT_W'(1)) begin
                    pend_v[r] = 1'b0;
                end
            end
`endif
        end
    end

    assign raw      = id_out_valid & ((id_rs1_ren & pend_v[id_rs1]) | (id_rs2_ren & pend_v[id_rs2]));
    assign waw_sat  = id_out_valid & id_wen & sat_v[id_rd];
    assign stall_id = raw | waw_sat;
    assign sb_empty = ~|nz_v;
    assign sb_err   = err_q;

    assign iss = id_out_valid & id_out_ready & ~stall_id & id_wen & (id_rd != '0);

    // Counter next-state: issue and retire on the same register cancel.
    always_comb begin
        err_d = err_q | (ret & ~nz_v[wb_rd]);
        inc_v = '0;
        dec_v = '0;
        for (int unsigned r = 1; r < NR_REG; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_v[r] = iss & (id_rd == IDX_W'(r));
            dec_v[r] = ret & (wb_rd == IDX_W'(r));
            if (inc_v[r] && !dec_v[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_v[r] && !inc_v[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            for (int unsigned r = 1; r < NR_REG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int unsigned r = 1; r < NR_REG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: doc/ysyx_24100006_scoreboard.md
# ysyx_24100006_scoreboard

Register-write scoreboard for the in-order RV32E pipeline, sitting beside the ID stage. It records the GPR destination when an instruction leaves ID and clears it when the WB stage retires that write. ID uses its `stall_id` output to hold any instruction whose sources are still owed a result. It is the producer/retire-side tracker: it keeps per-register pending state instead of comparing live stage `rd` fields, which covers load-use and multi-cycle MEM without per-stage special cases.

## Interface
Parameters:
- `CNT_W`, 2: width of each per-register pending counter; at most 2^CNT_W−1 writes to one register may be in flight.
- `NR_REG`, 16: number of GPRs; register index width is fixed at 4.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `id_out_valid`  in  1  ID holds a valid decoded instruction.
- `id_out_ready`  in  1  EX can accept from ID this cycle.
- `id_rs1`, `id_rs2`  in  4 each  source register indices.
- `id_rs1_ren`, `id_rs2_ren`  in  1 each  source actually read.
- `id_rd`  in  4  destination index.
- `id_wen`  in  1  instruction writes `id_rd`.
- `wb_commit`  in  1  WB writes the register file this cycle; a single-cycle pulse per retired write.
- `wb_rd`  in  4  retiring destination.
- `wb_wen`  in  1  retiring instruction writes `wb_rd`.
- `stall_id`  out  1  combinational; ID must not hand off.
- `sb_empty`  out  1  combinational; no register pending. Used for fence/ebreak drain.
- `sb_err`  out  1  registered, sticky; a retire arrived for a register with count 0.

## Operation
- State: `cnt[r]`, CNT_W bits, for r = 1..15. `cnt[0]` does not exist and always reads 0.
- `raw = id_out_valid & ((id_rs1_ren & cnt[id_rs1]!=0) | (id_rs2_ren & cnt[id_rs2]!=0))`. Register x0 is never pending.
- `waw_sat = id_out_valid & id_wen & id_rd!=0 & cnt[id_rd]==MAX`, where MAX = 2^CNT_W−1.
- `stall_id = raw | waw_sat`.
- Issue: `iss = id_out_valid & id_out_ready & ~stall_id & id_wen & id_rd!=0`.
- Retire: `ret = wb_commit & wb_wen & wb_rd!=0`.
- Per-register update each cycle:
  - iss only on r: +1.
  - ret only on r: −1.
  - both on the same r: unchanged.
  - iss on r and ret on s≠r: each updated independently.
- Retire on a count of 0: the count stays 0 (no wrap), and `sb_err` sets and stays set until reset.
- `sb_empty` = AND over r of (`cnt[r]==0`).
- A stalled instruction is not issued, so its `rd` is not marked. A stall is independent of `id_out_ready`.
- WAW below saturation is allowed. The pipeline is in-order, so retires arrive in issue order.

## Timing
- Reset values: all `cnt` = 0, `sb_err` = 0. Consequently `stall_id` = 0 and `sb_empty` = 1.
- Counter updates are visible on `stall_id` the cycle after the issue or retire edge.
- Back-to-back dependency: an instruction issued in cycle N with rd=5 stalls a following reader of x5 from cycle N+1 until the cycle after its `wb_commit`, or the same cycle as `wb_commit` if bypass is enabled (see Configuration).
- Asserting `reset` mid-stream drops all pending state at once. The pipeline is reset together with the scoreboard, so no stale retire follows.
- `stall_id` has no combinational path from `wb_commit` unless bypass is enabled.

## Configuration
- `SB_WB_BYPASS_EN` defined:
  - A source r is not considered pending if `ret` targets r this cycle and `cnt[r]==1`. The register file is write-first, so the reader sees the new value.
  - `waw_sat` likewise ignores a register being retired this cycle.
  - This creates a combinational path from `wb_commit` to `stall_id`.
- Not defined: pending is `cnt[r]!=0` only. A reader leaves ID no earlier than one cycle after the writer's `wb_commit`.

## Test plan
- Reset, then idle: `stall_id`=0, `sb_empty`=1, `sb_err`=0. Assert `reset` mid-run with `cnt[3]`=2: all counters return to 0 asynchronously.
- Issue `rd=5` at cycle 0, then at cycle 1 present a reader with `rs1=5, rs1_ren=1` → `stall_id`=1. Pulse `wb_commit` with `wb_rd=5` at cycle 4:
  - Without the macro, `stall_id` drops at cycle 5.
  - With `SB_WB_BYPASS_EN`, `stall_id` drops at cycle 4.
- Issue `rd=0`, and separately a reader with `rs2=0`: no counter changes, `stall_id`=0. Issue `rd=7` with `rs1=7, rs1_ren=0`: no stall.
- Three issues to `rd=9` (CNT_W=2) → `cnt[9]`=3. A fourth writer of x9 sees `stall_id`=1 from `waw_sat`. One retire of x9 → the fourth issues the next cycle.
- Same-cycle issue `rd=4` and retire `wb_rd=4` with `cnt[4]`=1 → `cnt[4]` stays 1. Same cycle issue `rd=4` and retire `wb_rd=6` → `cnt[4]`+1, `cnt[6]`−1.
- Retire `wb_rd=8` with `cnt[8]`=0 → `cnt[8]` stays 0 and `sb_err`=1 on the next cycle, remaining set through later traffic until `reset`.
